// File: rtl/ifetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// ifetch_unit_pkg
// Shared definitions for the instruction fetch unit: FSM state encodings,
// fault codes, the NOP instruction word and the default reset PC.
// ----------------------------------------------------------------------------
package ifetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_HALT  = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_TIMEOUT  = 2'b01,
        FAULT_ILLEGAL  = 2'b10,
        FAULT_MISALIGN = 2'b11
    } fault_t;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;  // addi x0, x0, 0
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Only 32-bit (uncompressed) encodings are supported.
    function automatic logic is_legal_encoding(input logic [31:0] inst);
        return inst[1:0] == 2'b11;
    endfunction

endpackage

// File: rtl/ifetch_unit_npc_sel.sv
// ----------------------------------------------------------------------------
// npc_sel
// Combinational next-PC selection and target alignment check.
//   pc         : current instruction address
//   imm        : sign-extended immediate
//   branch     : decoded branch flag
//   jump       : decoded JAL flag (wins over branch)
//   zero       : ALU zero flag
//   npc        : selected next PC (modulo 2^32)
//   misaligned : npc is not word aligned
// ----------------------------------------------------------------------------
module npc_sel (
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
    output logic [31:0] npc,
    output logic        misaligned
);

    logic take_target;

    assign take_target = jump || (branch && zero);
    assign npc         = take_target ? (pc + imm) : (pc + 32'd4);
    assign misaligned  = npc[1:0] != 2'b00;

endmodule

// File: rtl/ifetch_unit.sv
// ----------------------------------------------------------------------------
// ifetch_unit
// Multi-cycle instruction fetch sequencer: IDLE -> FETCH -> EXEC -> FETCH ...
// with a sticky HALT state entered on fetch timeout, illegal encoding or a
// misaligned next PC.
//   clk, rst_n          : clock, synchronous active-low reset
//   inst_in, MIO_ready  : instruction memory return data / handshake
//   Branch, Jump, zero  : control-unit / ALU flags for the current instruction
//   imm                 : sign-extended immediate
//   PC_out, PC_plus4    : current address and its link value
//   fetch_req           : instruction read request (FETCH only)
//   inst_reg            : latched instruction, with OPcode/Fun3/Fun7 fields
//   inst_valid          : one-cycle decode/execute strobe (EXEC only)
//   halted, fault_code  : stopped-on-fault indication and cause
// ----------------------------------------------------------------------------
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst_in,
    input  logic        MIO_ready,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        zero,
    input  logic [31:0] imm,
    output logic [31:0] PC_out,
    output logic [31:0] PC_plus4,
    output logic        fetch_req,
    output logic [31:0] inst_reg,
    output logic [4:0]  OPcode,
    output logic [2:0]  Fun3,
    output logic        Fun7,
    output logic        inst_valid,
    output logic        halted,
    output logic [1:0]  fault_code
);

    // Counter only needs to hold 0 .. TIMEOUT-1.
    localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   inst_q, inst_d;
    logic [CW-1:0] cnt_q, cnt_d;
    fault_t        fault_q, fault_d;

    logic [31:0]   npc;
    logic          npc_misaligned;

    npc_sel u_npc_sel (
        .pc         (pc_q),
        .imm        (imm),
        .branch     (Branch),
        .jump       (Jump),
        .zero       (zero),
        .npc        (npc),
        .misaligned (npc_misaligned)
    );

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;

        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
                cnt_d   = '0;
            end

            ST_FETCH: begin
                if (MIO_ready) begin
                    inst_d = inst_in;
                    cnt_d  = '0;
                    if (is_legal_encoding(inst_in)) begin
                        state_d = ST_EXEC;
                    end else begin
                        state_d = ST_HALT;
                        fault_d = FAULT_ILLEGAL;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HALT;
                    fault_d = FAULT_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_EXEC: begin
                // A misaligned target leaves PC on the faulting instruction.
                if (npc_misaligned) begin
                    state_d = ST_HALT;
                    fault_d = FAULT_MISALIGN;
                end else begin
                    pc_d    = npc;
                    state_d = ST_FETCH;
                end
            end

            ST_HALT: begin
                state_d = ST_HALT;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= NOP_INST;
            cnt_q   <= '0;
            fault_q <= FAULT_NONE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    // Strobes are gated by rst_n so they stay low throughout reset, even in
    // the cycle where the state register still holds FETCH or EXEC.
    assign fetch_req  = rst_n && (state_q == ST_FETCH);
    assign inst_valid = rst_n && (state_q == ST_EXEC);
    assign halted     = (state_q == ST_HALT);
    assign fault_code = fault_q;

    assign PC_out   = pc_q;
    assign PC_plus4 = pc_q + 32'd4;
    assign inst_reg = inst_q;
    assign OPcode   = inst_q[6:2];
    assign Fun3     = inst_q[14:12];
    assign Fun7     = inst_q[30];

endmodule

// File: tb/tb_ifetch_unit.sv
// ----------------------------------------------------------------------------
// tb_ifetch_unit
// Directed bench for ifetch_unit with a 16-word instruction memory model
// addressed by PC_out[5:2]. Inputs change 1 ns after a rising edge; outputs
// are sampled at the same point.
// ----------------------------------------------------------------------------
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] inst_in;
    logic        MIO_ready;
    logic        Branch;
    logic        Jump;
    logic        zero;
    logic [31:0] imm;
    logic [31:0] PC_out;
    logic [31:0] PC_plus4;
    logic        fetch_req;
    logic [31:0] inst_reg;
    logic [4:0]  OPcode;
    logic [2:0]  Fun3;
    logic        Fun7;
    logic        inst_valid;
    logic        halted;
    logic [1:0]  fault_code;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [16];

    localparam logic [31:0] I_ADDI = 32'h0010_0093;  // addi x1, x0, 1
    localparam logic [31:0] I_SUB  = 32'h4020_8133;  // sub  x2, x1, x2
    localparam logic [31:0] I_SW   = 32'h0020_2023;  // sw   x2, 0(x0)
    localparam logic [31:0] I_NOP  = 32'h0000_0013;

    always #5 clk = ~clk;

    assign inst_in = mem[PC_out[5:2]];

    ifetch_unit #(
        .RESET_PC (32'h0000_0000),
        .TIMEOUT  (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inst_in    (inst_in),
        .MIO_ready  (MIO_ready),
        .Branch     (Branch),
        .Jump       (Jump),
        .zero       (zero),
        .imm        (imm),
        .PC_out     (PC_out),
        .PC_plus4   (PC_plus4),
        .fetch_req  (fetch_req),
        .inst_reg   (inst_reg),
        .OPcode     (OPcode),
        .Fun3       (Fun3),
        .Fun7       (Fun7),
        .inst_valid (inst_valid),
        .halted     (halted),
        .fault_code (fault_code)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctrl(input logic j, input logic b, input logic z, input logic [31:0] im);
        Jump   = j;
        Branch = b;
        zero   = z;
        imm    = im;
    endtask

    // Two reset edges, then release; the current cycle afterwards is IDLE.
    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Finish EXEC and land in the next FETCH.
    task automatic exec_then_fetch();
        step();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = I_NOP;
        mem[0] = I_ADDI;
        mem[1] = I_SUB;
        mem[2] = I_SW;
        rst_n     = 1'b0;
        MIO_ready = 1'b1;
        set_ctrl(1'b0, 1'b0, 1'b0, 32'd0);

        // ---------------- reset state ----------------
        step();
        check("rst fetch_req", {31'd0, fetch_req}, 32'd0);
        check("rst inst_valid", {31'd0, inst_valid}, 32'd0);
        step();
        check("rst PC_out", PC_out, 32'h0);
        check("rst inst_reg", inst_reg, I_NOP);
        check("rst halted", {31'd0, halted}, 32'd0);
        check("rst fault", {30'd0, fault_code}, 32'd0);
        rst_n = 1'b1;
        check("idle fetch_req", {31'd0, fetch_req}, 32'd0);

        // ---------------- zero-wait sequence ----------------
        step();
        check("f0 fetch_req", {31'd0, fetch_req}, 32'd1);
        check("f0 PC", PC_out, 32'h0);
        step();
        check("e0 valid", {31'd0, inst_valid}, 32'd1);
        check("e0 req", {31'd0, fetch_req}, 32'd0);
        check("e0 OPcode", {27'd0, OPcode}, 32'b00100);
        check("e0 Fun7", {31'd0, Fun7}, 32'd0);
        step();
        check("f1 valid", {31'd0, inst_valid}, 32'd0);
        check("f1 PC", PC_out, 32'h4);
        step();
        check("e1 valid", {31'd0, inst_valid}, 32'd1);
        check("e1 OPcode", {27'd0, OPcode}, 32'b01100);
        check("e1 Fun7", {31'd0, Fun7}, 32'd1);
        step();
        check("f2 PC", PC_out, 32'h8);
        step();
        check("e2 valid", {31'd0, inst_valid}, 32'd1);
        check("e2 OPcode", {27'd0, OPcode}, 32'b01000);
        check("e2 Fun3", {29'd0, Fun3}, 32'b010);
        check("e2 PC_plus4", PC_plus4, 32'hC);

        // ---------------- wait states ----------------
        MIO_ready = 1'b0;
        step();
        check("w PC", PC_out, 32'hC);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("w req%0d", i), {31'd0, fetch_req}, 32'd1);
            check($sformatf("w valid%0d", i), {31'd0, inst_valid}, 32'd0);
            if (i == 4) MIO_ready = 1'b1;
            step();
        end
        check("w exec valid", {31'd0, inst_valid}, 32'd1);
        check("w halted", {31'd0, halted}, 32'd0);
        check("w fault", {30'd0, fault_code}, 32'd0);
        step();
        check("w next PC", PC_out, 32'h10);

        // ---------------- branches ----------------
        set_ctrl(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
        exec_then_fetch();
        check("beq taken PC", PC_out, 32'h08);
        set_ctrl(1'b0, 1'b1, 1'b0, 32'hFFFF_FFF8);
        exec_then_fetch();
        check("beq not taken PC", PC_out, 32'h0C);
        set_ctrl(1'b0, 1'b0, 1'b0, 32'd0);
        exec_then_fetch();
        check("seq PC", PC_out, 32'h10);
        set_ctrl(1'b0, 1'b1, 1'b0, 32'hFFFF_FFF8);
        exec_then_fetch();
        check("nt from 0x10 PC", PC_out, 32'h14);

        // Jump over a not-taken branch: JAL target, not PC+4.
        set_ctrl(1'b1, 1'b1, 1'b0, 32'h0000_000C);
        exec_then_fetch();
        check("jump prio PC", PC_out, 32'h20);

        // ---------------- wrap-around ----------------
        set_ctrl(1'b1, 1'b0, 1'b0, 32'hFFFF_FFDC);
        exec_then_fetch();
        check("jump top PC", PC_out, 32'hFFFF_FFFC);
        set_ctrl(1'b0, 1'b0, 1'b0, 32'd0);
        step();
        check("top PC_plus4", PC_plus4, 32'h0);
        step();
        check("wrap PC", PC_out, 32'h0);
        check("wrap halted", {31'd0, halted}, 32'd0);

        // ---------------- misaligned target ----------------
        set_ctrl(1'b1, 1'b0, 1'b0, 32'h0000_0020);
        exec_then_fetch();
        check("back to 0x20", PC_out, 32'h20);
        set_ctrl(1'b1, 1'b1, 1'b1, 32'h0000_0102);
        step();
        check("mis exec valid", {31'd0, inst_valid}, 32'd1);
        step();
        check("mis halted", {31'd0, halted}, 32'd1);
        check("mis fault", {30'd0, fault_code}, 32'b11);
        check("mis PC", PC_out, 32'h20);
        for (int i = 0; i < 3; i++) step();
        check("halt sticky", {31'd0, halted}, 32'd1);
        check("halt req", {31'd0, fetch_req}, 32'd0);
        check("halt valid", {31'd0, inst_valid}, 32'd0);
        check("halt PC", PC_out, 32'h20);
        set_ctrl(1'b0, 1'b0, 1'b0, 32'd0);

        // ---------------- fetch timeout ----------------
        MIO_ready = 1'b0;
        do_reset();
        step();
        for (int i = 0; i < 16; i++) begin
            check($sformatf("to req%0d", i), {31'd0, fetch_req}, 32'd1);
            step();
        end
        check("to halted", {31'd0, halted}, 32'd1);
        check("to fault", {30'd0, fault_code}, 32'b01);

        // Ready on the final allowed cycle still succeeds.
        do_reset();
        step();
        for (int i = 0; i < 16; i++) begin
            if (i == 15) MIO_ready = 1'b1;
            step();
        end
        check("late valid", {31'd0, inst_valid}, 32'd1);
        check("late halted", {31'd0, halted}, 32'd0);
        check("late fault", {30'd0, fault_code}, 32'd0);

        // ---------------- illegal encoding ----------------
        mem[0]    = 32'h0000_0000;
        MIO_ready = 1'b1;
        do_reset();
        step();
        check("ill fetch valid", {31'd0, inst_valid}, 32'd0);
        step();
        check("ill halted", {31'd0, halted}, 32'd1);
        check("ill fault", {30'd0, fault_code}, 32'b10);
        check("ill valid", {31'd0, inst_valid}, 32'd0);

        // ---------------- reset mid-FETCH ----------------
        mem[0] = I_ADDI;
        do_reset();
        step();
        step();
        step();
        check("pre-rst PC", PC_out, 32'h4);
        rst_n = 1'b0;
        step();
        check("mid rst PC", PC_out, 32'h0);
        check("mid rst inst_reg", inst_reg, I_NOP);
        check("mid rst req", {31'd0, fetch_req}, 32'd0);
        rst_n = 1'b1;
        check("post rst idle req", {31'd0, fetch_req}, 32'd0);
        check("post rst idle valid", {31'd0, inst_valid}, 32'd0);
        step();
        check("post rst fetch req", {31'd0, fetch_req}, 32'd1);
        check("post rst fetch PC", PC_out, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
